instr_mem_stream_loader: RTL and testbench

- Parametrised instruction memory for the pipelined MIPS core with a built-in byte-stream program loader.
- The debug unit feeds program bytes (e.g. from the UART receiver). The block assembles them into words, writes them sequentially from address 0, and detects the HALT word to end loading.
- The fetch stage reads through a port with configurable latency (1 or 2 cycles) and a valid flag.
- The memory carries no initialisation file; all program contents arrive through the loader.

---
 rtl/instr_mem_stream_loader.sv | 157 +++++++++++++++
 tb/tb_instr_mem_stream_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_stream_loader.sv
// Instruction memory with a byte-stream program loader (MSB-first word assembly,
// HALT detection) and a 1- or 2-cycle fetch read port with address-error flag.
module instr_mem_stream_loader #(
  parameter int                      MEMORY_WIDTH = 32,
  parameter int                      NB_BYTE      = 8,
  parameter int                      NB_ADDR      = 8,
  parameter int                      MEMORY_DEPTH = 256,
  parameter int                      OUTPUT_REG   = 0,
  parameter logic [MEMORY_WIDTH-1:0] HALT_WORD    = {MEMORY_WIDTH{1'b1}}
) (
  input  logic                    i_clock,
  input  logic                    rstb,
  input  logic                    i_load_start,
  input  logic                    i_byte_valid,
  input  logic [NB_BYTE-1:0]      i_byte,
  output logic                    o_load_busy,
  output logic                    o_load_done,
  output logic                    o_load_full,
  output logic [NB_ADDR:0]        o_words_loaded,
  input  logic                    i_read_enable,
  input  logic [NB_ADDR-1:0]      i_read_addr,
  output logic [MEMORY_WIDTH-1:0] o_data,
  output logic                    o_data_valid,
  output logic                    o_addr_error
);

  localparam int BPW    = MEMORY_WIDTH / NB_BYTE;
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int NB_IDX = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);
  localparam logic [NB_ADDR:0]  DEPTH_W   = (NB_ADDR + 1)'(MEMORY_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                         r_state, w_next;
  logic [NB_CNT-1:0]              r_bcnt;
  logic [NB_ADDR:0]               r_wptr;
  logic [MEMORY_WIDTH-NB_BYTE-1:0] r_asm;
  logic                           r_busy, r_done, r_full;
  logic [MEMORY_WIDTH-1:0]        w_word;
  logic                           w_clr, w_accept, w_last, w_wr, w_set_full;

  logic [MEMORY_WIDTH-1:0] mem [0:MEMORY_DEPTH-1];

  assign w_word = {r_asm, i_byte};
  assign w_last = (r_bcnt == LAST_BYTE);

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_accept   = 1'b0;
    w_wr       = 1'b0;
    w_set_full = 1'b0;
    if (i_load_start) begin
      w_clr  = 1'b1;
      w_next = LOAD;
    end else if (r_state == LOAD && i_byte_valid) begin
      w_accept = 1'b1;
      if (w_last) begin
        w_wr = !rstb && (r_wptr < DEPTH_W);
        // HALT wins over full when both happen on the same word
        if (w_word == HALT_WORD) begin
          w_next = DONE;
        end else if (r_wptr + 1'b1 == DEPTH_W) begin
          w_next     = DONE;
          w_set_full = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (rstb) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_wptr  <= '0;
      r_asm   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == LOAD);
      r_done  <= (w_next == DONE);
      if (w_clr) begin
        r_bcnt <= '0;
        r_wptr <= '0;
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_asm <= w_word[MEMORY_WIDTH-NB_BYTE-1:0];
        if (w_last) begin
          r_bcnt <= '0;
          if (w_wr) r_wptr <= r_wptr + 1'b1;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
        if (w_set_full) r_full <= 1'b1;
      end
    end
  end

  // Array has no reset so it maps onto block RAM
  always_ff @(posedge i_clock) begin
    if (w_wr) mem[r_wptr[NB_IDX-1:0]] <= w_word;
  end

  assign o_load_busy    = r_busy;
  assign o_load_done    = r_done;
  assign o_load_full    = r_full;
  assign o_words_loaded = r_wptr;

  logic [MEMORY_WIDTH-1:0] r_rd1;
  logic                    r_vld1, r_err1;
  logic                    w_rd_in_rng, w_rd_err;

  assign w_rd_in_rng = ({1'b0, i_read_addr} < DEPTH_W);
  assign w_rd_err    = ({1'b0, i_read_addr} >= r_wptr);

  always_ff @(posedge i_clock) begin
    if (rstb) begin
      r_rd1  <= '0;
      r_vld1 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_vld1 <= i_read_enable;
      r_err1 <= i_read_enable & w_rd_err;
      if (i_read_enable)
        r_rd1 <= w_rd_in_rng ? mem[i_read_addr[NB_IDX-1:0]] : '0;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [MEMORY_WIDTH-1:0] r_rd2;
      logic                    r_vld2, r_err2;
      always_ff @(posedge i_clock) begin
        if (rstb) begin
          r_rd2  <= '0;
          r_vld2 <= 1'b0;
          r_err2 <= 1'b0;
        end else begin
          r_rd2  <= r_rd1;
          r_vld2 <= r_vld1;
          r_err2 <= r_err1;
        end
      end
      assign o_data       = r_rd2;
      assign o_data_valid = r_vld2;
      assign o_addr_error = r_err2;
    end else begin : g_noreg
      assign o_data       = r_rd1;
      assign o_data_valid = r_vld1;
      assign o_addr_error = r_err1;
    end
  endgenerate

endmodule

// File: tb/tb_instr_mem_stream_loader.sv
// Directed bench: dut A (depth 256, 1-cycle read) and dut B (depth 4, 2-cycle read)
// share one stimulus stream and are checked against hand-computed values.
module tb_instr_mem_stream_loader;
  logic        i_clock = 1'b0;
  logic        rstb = 1'b1;
  logic        ld = 1'b0, bv = 1'b0, re = 1'b0;
  logic [7:0]  bt = '0, ra = '0;

  logic        a_busy, a_done, a_full, a_vld, a_err;
  logic [8:0]  a_words;
  logic [31:0] a_data;
  logic        b_busy, b_done, b_full, b_vld, b_err;
  logic [8:0]  b_words;
  logic [31:0] b_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clock = ~i_clock;

  instr_mem_stream_loader #(.MEMORY_DEPTH(256), .OUTPUT_REG(0)) dut_a (
    .i_clock(i_clock), .rstb(rstb), .i_load_start(ld), .i_byte_valid(bv), .i_byte(bt),
    .o_load_busy(a_busy), .o_load_done(a_done), .o_load_full(a_full), .o_words_loaded(a_words),
    .i_read_enable(re), .i_read_addr(ra), .o_data(a_data), .o_data_valid(a_vld),
    .o_addr_error(a_err));

  instr_mem_stream_loader #(.MEMORY_DEPTH(4), .OUTPUT_REG(1)) dut_b (
    .i_clock(i_clock), .rstb(rstb), .i_load_start(ld), .i_byte_valid(bv), .i_byte(bt),
    .o_load_busy(b_busy), .o_load_done(b_done), .o_load_full(b_full), .o_words_loaded(b_words),
    .i_read_enable(re), .i_read_addr(ra), .o_data(b_data), .o_data_valid(b_vld),
    .o_addr_error(b_err));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bv = 1'b1; bt = b;
    tick();
    bv = 1'b0;
  endtask

  task automatic start();
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  // single read: A checked after one edge, B after two
  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] ea,
                    input logic ea_err, input logic [31:0] eb, input logic eb_err);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0;
    chk({tag, "_a_vld"}, a_vld, 1'b1);
    chk({tag, "_a_dat"}, a_data, ea);
    chk({tag, "_a_err"}, a_err, ea_err);
    chk({tag, "_b_early"}, b_vld, 1'b0);
    tick();
    chk({tag, "_b_vld"}, b_vld, 1'b1);
    chk({tag, "_b_dat"}, b_data, eb);
    chk({tag, "_b_err"}, b_err, eb_err);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_a_busy"}, a_busy, 1'b0);
    chk({tag, "_a_done"}, a_done, 1'b0);
    chk({tag, "_a_full"}, a_full, 1'b0);
    chk({tag, "_a_words"}, a_words, 9'd0);
    chk({tag, "_a_data"}, a_data, 32'd0);
    chk({tag, "_a_vld"}, a_vld, 1'b0);
    chk({tag, "_a_err"}, a_err, 1'b0);
    chk({tag, "_b_busy"}, b_busy, 1'b0);
    chk({tag, "_b_done"}, b_done, 1'b0);
    chk({tag, "_b_full"}, b_full, 1'b0);
    chk({tag, "_b_words"}, b_words, 9'd0);
    chk({tag, "_b_data"}, b_data, 32'd0);
    chk({tag, "_b_vld"}, b_vld, 1'b0);
  endtask

  logic [7:0]  pa [4];
  logic [31:0] pw [3];

  initial begin
    pa = '{8'd0, 8'd1, 8'd2, 8'd5};
    pw = '{32'h00112233, 32'h44556677, 32'hFFFFFFFF};

    tick(); tick();
    rstb = 1'b0;
    chk_idle_outputs("rst");

    // two plain words
    start();
    for (int i = 0; i < 8; i++) send(8'(8'h11 * i));
    chk("ld2_a_words", a_words, 9'd2);
    chk("ld2_a_busy", a_busy, 1'b1);
    chk("ld2_a_done", a_done, 1'b0);
    chk("ld2_b_words", b_words, 9'd2);

    // HALT word ends the load
    for (int i = 0; i < 3; i++) send(8'hFF);
    chk("halt_pre_done", a_done, 1'b0);
    send(8'hFF);
    chk("halt_a_done", a_done, 1'b1);
    chk("halt_a_busy", a_busy, 1'b0);
    chk("halt_a_full", a_full, 1'b0);
    chk("halt_a_words", a_words, 9'd3);
    chk("halt_b_done", b_done, 1'b1);
    chk("halt_b_full", b_full, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h12 + 8'(i));
    chk("post_halt_a_words", a_words, 9'd3);
    chk("post_halt_a_done", a_done, 1'b1);

    // back-to-back reads 0,1,2,5: A 1-cycle latency, B 2-cycle latency
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin re = 1'b1; ra = pa[c]; end
      else re = 1'b0;
      tick();
      if (c < 4) begin
        chk($sformatf("pipe_a_vld%0d", c), a_vld, 1'b1);
        chk($sformatf("pipe_a_err%0d", c), a_err, pa[c] == 8'd5);
        if (c < 3) chk($sformatf("pipe_a_dat%0d", c), a_data, pw[c]);
      end else begin
        chk($sformatf("pipe_a_vld%0d", c), a_vld, 1'b0);
      end
      if (c >= 1 && c <= 4) begin
        chk($sformatf("pipe_b_vld%0d", c), b_vld, 1'b1);
        chk($sformatf("pipe_b_err%0d", c), b_err, pa[c-1] == 8'd5);
        chk($sformatf("pipe_b_dat%0d", c), b_data, (c <= 3) ? pw[c-1] : 32'd0);
      end else begin
        chk($sformatf("pipe_b_vld%0d", c), b_vld, 1'b0);
      end
    end
    re = 1'b0;

    // fill: B (depth 4) reaches full, A keeps loading
    start();
    for (int i = 1; i <= 16; i++) send(8'(i));
    chk("full_a_words", a_words, 9'd4);
    chk("full_a_busy", a_busy, 1'b1);
    chk("full_a_full", a_full, 1'b0);
    chk("full_b_words", b_words, 9'd4);
    chk("full_b_full", b_full, 1'b1);
    chk("full_b_done", b_done, 1'b1);
    chk("full_b_busy", b_busy, 1'b0);
    send(8'h11);
    chk("full17_b_words", b_words, 9'd4);
    chk("full17_b_full", b_full, 1'b1);
    rd("full_rd3", 8'd3, 32'h0D0E0F10, 1'b0, 32'h0D0E0F10, 1'b0);

    // read-during-write of mem[0] returns the old word
    start();
    chk("restart_b_full", b_full, 1'b0);
    chk("restart_b_words", b_words, 9'd0);
    chk("restart_b_busy", b_busy, 1'b1);
    send(8'hA1); send(8'hA2); send(8'hA3);
    bv = 1'b1; bt = 8'hA4; re = 1'b1; ra = 8'd0;
    tick();
    bv = 1'b0; re = 1'b0;
    chk("rdw_a_dat", a_data, 32'h01020304);
    chk("rdw_a_err", a_err, 1'b1);
    tick();
    chk("rdw_b_dat", b_data, 32'h01020304);
    chk("rdw_b_err", b_err, 1'b1);
    rd("rdw_new", 8'd0, 32'hA1A2A3A4, 1'b0, 32'hA1A2A3A4, 1'b0);

    // load start mid-word discards the partial word and the coincident byte
    start();
    send(8'h55); send(8'h66);
    ld = 1'b1; bv = 1'b1; bt = 8'hAA;
    tick();
    ld = 1'b0; bv = 1'b0;
    chk("restart_mid_words", a_words, 9'd0);
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("restart_a_words", a_words, 9'd1);
    chk("restart_b_words2", b_words, 9'd1);
    rd("restart_rd0", 8'd0, 32'h01020304, 1'b0, 32'h01020304, 1'b0);
    rd("restart_rd1", 8'd1, 32'h05060708, 1'b1, 32'h05060708, 1'b1);

    // reset in the middle of a load
    start();
    for (int i = 0; i < 6; i++) send(8'h11 * 8'(i + 1));
    chk("mid_a_words", a_words, 9'd1);
    rd("mid_rd0", 8'd0, 32'h11223344, 1'b0, 32'h11223344, 1'b0);
    rstb = 1'b1; bv = 1'b1; bt = 8'h77; re = 1'b1; ra = 8'd0;
    tick();
    rstb = 1'b0; bv = 1'b0; re = 1'b0;
    chk_idle_outputs("midrst");
    chk("midrst_b_err", b_err, 1'b0);
    send(8'h77); send(8'h88); send(8'h99); send(8'hAB);
    chk("midrst_ign_words", a_words, 9'd0);
    chk("midrst_ign_busy", a_busy, 1'b0);
    rd("midrst_rd0", 8'd0, 32'h11223344, 1'b1, 32'h11223344, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
